// File: rtl/alu_instr_encoder_pkg.sv
// alu_instr_encoder_pkg: ALU op codes, RV32I opcode/funct constants
// and the request-to-instruction encoder function.
package alu_instr_encoder_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_op_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] ILLEGAL_WORD = 32'hDEADBEEF;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= ALU_AUIPC;
  endfunction

  function automatic logic [31:0] r_type(
    input logic [6:0] f7,
    input logic [2:0] f3,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] encode_alu(
    input logic [3:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [19:0] imm
  );
    logic [31:0] w;
    w = ILLEGAL_WORD;
    case (op)
      ALU_ADD:   w = r_type(F7_BASE, F3_ADD, rd, rs1, rs2);
      ALU_SUB:   w = r_type(F7_ALT, F3_ADD, rd, rs1, rs2);
      ALU_AND:   w = r_type(F7_BASE, F3_AND, rd, rs1, rs2);
      ALU_OR:    w = r_type(F7_BASE, F3_OR, rd, rs1, rs2);
      ALU_XOR:   w = r_type(F7_BASE, F3_XOR, rd, rs1, rs2);
      ALU_SLL:   w = r_type(F7_BASE, F3_SLL, rd, rs1, rs2);
      ALU_SRL:   w = r_type(F7_BASE, F3_SR, rd, rs1, rs2);
      ALU_SRA:   w = r_type(F7_ALT, F3_SR, rd, rs1, rs2);
      ALU_SLT:   w = r_type(F7_BASE, F3_SLT, rd, rs1, rs2);
      ALU_SLTU:  w = r_type(F7_BASE, F3_SLTU, rd, rs1, rs2);
      ALU_LUI:   w = {imm, rd, OPC_LUI};
      ALU_AUIPC: w = {imm, rd, OPC_AUIPC};
      default:   w = ILLEGAL_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/alu_instr_encoder_fifo.sv
// alu_enc_fifo: circular buffer of encoded words with occupancy count.
// Ports: i_push/i_pop/i_flush, i_wdata in; o_rdata (0 when empty),
// o_count, o_full, o_empty out.
module alu_enc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic                           i_flush,
  input  logic [WIDTH-1:0]               i_wdata,
  output logic [WIDTH-1:0]               o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_full,
  output logic                           o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_count = r_count;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;

  // Guards here so the buffer stays consistent whatever the caller does.
  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_instr_encoder.sv
// alu_instr_encoder: encodes ALU requests to RV32I words, buffers them
// and issues them with an issue-order PC.
// Ports: req_* valid/ready request in; instr_valid/instr_ready/instr/
// instr_pc issue out; flush/flush_pc; count; illegal_err.
// Build option ALU_ENC_ILLEGAL_TRAP_EN: illegal ops are acked, dropped
// and flagged in sticky illegal_err instead of queued as DEADBEEF.
module alu_instr_encoder
  import alu_instr_encoder_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [3:0]                 req_op,
  input  logic [4:0]                 req_rd,
  input  logic [4:0]                 req_rs1,
  input  logic [4:0]                 req_rs2,
  input  logic [19:0]                req_imm,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [31:0]                instr,
  output logic [31:0]                instr_pc,
  input  logic                       flush,
  input  logic [31:0]                flush_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       illegal_err
);

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_enc;
  logic [31:0] r_pc;

  assign req_ready = !w_full && !flush;
  assign w_accept  = req_valid && req_ready;
  assign w_enc     = encode_alu(req_op, req_rd, req_rs1, req_rs2, req_imm);
  assign w_pop     = instr_valid && instr_ready && !flush;

`ifdef ALU_ENC_ILLEGAL_TRAP_EN
  logic w_illegal;
  logic r_err;

  assign w_illegal   = !is_legal(req_op);
  assign w_push      = w_accept && !w_illegal;
  assign illegal_err = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (flush) begin
      r_err <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_push      = w_accept;
  assign illegal_err = 1'b0;
`endif

  alu_enc_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_wdata (w_enc),
    .o_rdata (instr),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign instr_valid = !w_empty;
  assign instr_pc    = r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= PC_RESET;
    end else if (flush) begin
      r_pc <= flush_pc;
    end else if (w_pop) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

endmodule

// File: tb/tb_alu_instr_encoder.sv
// tb_alu_instr_encoder: directed-vector bench for alu_instr_encoder.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [4:0]  req_rs1 = 5'd0;
  logic [4:0]  req_rs2 = 5'd0;
  logic [19:0] req_imm = 20'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'd0;
  logic [2:0]  count;
  logic        illegal_err;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_instr_encoder #(
    .DEPTH    (DEPTH),
    .PC_RESET (32'h0000_0000),
    .PC_STEP  (32'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rd      (req_rd),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_imm     (req_imm),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .count       (count),
    .illegal_err (illegal_err)
  );

  task automatic set_req(input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [19:0] imm);
    req_valid = 1'b1;
    req_op    = op;
    req_rd    = rd;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_imm   = imm;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    @(negedge clk);
    req_valid = 1'b0;
    instr_ready = 1'b0;
    flush = 1'b1;
    flush_pc = pc;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_total++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", instr_valid); else n_pass++;
    n_total++; if (instr !== 32'h0) $display("FAIL reset_instr got %h want 0", instr); else n_pass++;
    n_total++; if (instr_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", instr_pc); else n_pass++;
    n_total++; if (illegal_err !== 1'b0) $display("FAIL reset_err got %b want 0", illegal_err); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_add_latency;
    @(negedge clk);
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 20'd0);
    #1;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL add_no_bypass got %b want 0", instr_valid); else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    n_total++; if (instr_valid !== 1'b1) $display("FAIL add_valid got %b want 1", instr_valid); else n_pass++;
    n_total++; if (instr !== 32'h003100B3) $display("FAIL add_instr got %h want 003100b3", instr); else n_pass++;
    n_total++; if (instr_pc !== 32'h0) $display("FAIL add_pc got %h want 0", instr_pc); else n_pass++;
    @(negedge clk);
    n_total++; if (instr !== 32'h003100B3) $display("FAIL add_hold got %h want 003100b3", instr); else n_pass++;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    n_total++; if (count !== 3'd0) $display("FAIL add_pop_count got %0d want 0", count); else n_pass++;
    n_total++; if (instr_pc !== 32'h4) $display("FAIL add_pop_pc got %h want 4", instr_pc); else n_pass++;
    do_flush(32'h0);
  endtask

  task automatic test_sub_lui;
    @(negedge clk);
    instr_ready = 1'b1;
    set_req(4'd1, 5'd5, 5'd6, 5'd7, 20'd0);
    @(negedge clk);
    set_req(4'd10, 5'd10, 5'd0, 5'd0, 20'h12345);
    n_total++; if (instr !== 32'h407302B3) $display("FAIL sub_instr got %h want 407302b3", instr); else n_pass++;
    n_total++; if (instr_pc !== 32'h0) $display("FAIL sub_pc got %h want 0", instr_pc); else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    n_total++; if (instr !== 32'h12345537) $display("FAIL lui_instr got %h want 12345537", instr); else n_pass++;
    n_total++; if (instr_pc !== 32'h4) $display("FAIL lui_pc got %h want 4", instr_pc); else n_pass++;
    @(negedge clk);
    n_total++; if (instr_valid !== 1'b0) $display("FAIL lui_drain got %b want 0", instr_valid); else n_pass++;
    n_total++; if (instr_pc !== 32'h8) $display("FAIL lui_next_pc got %h want 8", instr_pc); else n_pass++;
    do_flush(32'h0);
  endtask

  task automatic test_encodings;
    logic [3:0]  ops [3] = '{4'd7, 4'd9, 4'd2};
    logic [4:0]  rds [3] = '{5'd3, 5'd31, 5'd2};
    logic [4:0]  r1s [3] = '{5'd4, 5'd1, 5'd1};
    logic [4:0]  r2s [3] = '{5'd5, 5'd2, 5'd1};
    logic [31:0] exp [3] = '{32'h405251B3, 32'h0020BFB3, 32'h0010F133};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr_ready = 1'b1;
      set_req(ops[i], rds[i], r1s[i], r2s[i], 20'hFFFFF);
      @(negedge clk);
      req_valid = 1'b0;
      n_total++; if (instr !== exp[i]) $display("FAIL enc_%0d got %h want %h", i, instr, exp[i]); else n_pass++;
    end
    do_flush(32'h0);
  endtask

  task automatic test_fill_drain;
    logic [31:0] exp [DEPTH] = '{32'h000010B7, 32'h00002137, 32'h000031B7, 32'h00004237};
    for (int i = 0; i <= DEPTH; i++) begin
      @(negedge clk);
      set_req(4'd10, 5'(i + 1), 5'd0, 5'd0, 20'(i + 1));
      #1;
      n_total++; if (req_ready !== (i < DEPTH)) $display("FAIL fill_ready_%0d got %b want %b", i, req_ready, i < DEPTH); else n_pass++;
    end
    n_total++; if (count !== 3'(DEPTH)) $display("FAIL fill_count got %0d want %0d", count, DEPTH); else n_pass++;
    instr_ready = 1'b1;
    #1;
    n_total++; if (req_ready !== 1'b0) $display("FAIL full_pop_ready got %b want 0", req_ready); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      n_total++; if (instr !== exp[i]) $display("FAIL drain_instr_%0d got %h want %h", i, instr, exp[i]); else n_pass++;
      n_total++; if (instr_pc !== 32'(4 * i)) $display("FAIL drain_pc_%0d got %h want %h", i, instr_pc, 4 * i); else n_pass++;
      @(negedge clk);
      req_valid = 1'b0;
      if (i == 0) begin
        n_total++; if (count !== 3'(DEPTH - 1)) $display("FAIL full_no_push got %0d want %0d", count, DEPTH - 1); else n_pass++;
      end
    end
    n_total++; if (instr_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", instr_valid); else n_pass++;
    do_flush(32'h0);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 20'd0);
    @(negedge clk);
    instr_ready = 1'b1;
    set_req(4'd1, 5'd5, 5'd6, 5'd7, 20'd0);
    @(negedge clk);
    req_valid = 1'b0;
    n_total++; if (count !== 3'd1) $display("FAIL b2b_count got %0d want 1", count); else n_pass++;
    n_total++; if (instr !== 32'h407302B3) $display("FAIL b2b_instr got %h want 407302b3", instr); else n_pass++;
    n_total++; if (instr_pc !== 32'h4) $display("FAIL b2b_pc got %h want 4", instr_pc); else n_pass++;
    do_flush(32'h0);
  endtask

  task automatic test_wrap;
    do_flush(32'hFFFF_FFFC);
    set_req(4'd11, 5'd1, 5'd0, 5'd0, 20'h00001);
    #1;
    n_total++; if (instr_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_flush_pc got %h want fffffffc", instr_pc); else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    instr_ready = 1'b1;
    n_total++; if (instr !== 32'h00001097) $display("FAIL auipc_instr got %h want 00001097", instr); else n_pass++;
    n_total++; if (instr_pc !== 32'hFFFF_FFFC) $display("FAIL auipc_pc got %h want fffffffc", instr_pc); else n_pass++;
    @(negedge clk);
    instr_ready = 1'b0;
    n_total++; if (instr_pc !== 32'h0) $display("FAIL wrap_pc got %h want 0", instr_pc); else n_pass++;
  endtask

  task automatic test_flush_full;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      set_req(4'd3, 5'd1, 5'd1, 5'd1, 20'd0);
    end
    @(negedge clk);
    n_total++; if (count !== 3'(DEPTH)) $display("FAIL ff_count got %0d want %0d", count, DEPTH); else n_pass++;
    flush = 1'b1;
    flush_pc = 32'h100;
    instr_ready = 1'b1;
    #1;
    n_total++; if (req_ready !== 1'b0) $display("FAIL ff_ready got %b want 0", req_ready); else n_pass++;
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    instr_ready = 1'b0;
    n_total++; if (count !== 3'd0) $display("FAIL ff_flush_count got %0d want 0", count); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL ff_valid got %b want 0", instr_valid); else n_pass++;
    n_total++; if (instr_pc !== 32'h100) $display("FAIL ff_pc got %h want 100", instr_pc); else n_pass++;
    do_flush(32'h0);
  endtask

  task automatic test_illegal;
    @(negedge clk);
    set_req(4'hF, 5'd1, 5'd2, 5'd3, 20'd0);
    #1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL ill_ready got %b want 1", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
`ifdef ALU_ENC_ILLEGAL_TRAP_EN
    n_total++; if (count !== 3'd0) $display("FAIL ill_count got %0d want 0", count); else n_pass++;
    n_total++; if (illegal_err !== 1'b1) $display("FAIL ill_err got %b want 1", illegal_err); else n_pass++;
    @(negedge clk);
    n_total++; if (illegal_err !== 1'b1) $display("FAIL ill_sticky got %b want 1", illegal_err); else n_pass++;
    do_flush(32'h0);
    n_total++; if (illegal_err !== 1'b0) $display("FAIL ill_clear got %b want 0", illegal_err); else n_pass++;
`else
    n_total++; if (instr !== 32'hDEADBEEF) $display("FAIL ill_instr got %h want deadbeef", instr); else n_pass++;
    n_total++; if (count !== 3'd1) $display("FAIL ill_count got %0d want 1", count); else n_pass++;
    n_total++; if (illegal_err !== 1'b0) $display("FAIL ill_err got %b want 0", illegal_err); else n_pass++;
    do_flush(32'h0);
`endif
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_sub_lui();
    test_encodings();
    test_fill_drain();
    test_back_to_back();
    test_wrap();
    test_flush_full();
    test_illegal();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
